// File: rtl/egk_bin_decoder.sv
// rtl/egk_bin_decoder.sv - bit-serial k-th order Exp-Golomb bin-string decoder
// Define EGK_SIGNED_MAP_EN to map the decoded codeNum onto a signed value.
module egk_bin_decoder #(
   parameter int VALUE_WIDTH = 8,
   parameter int K           = 1,
   parameter int MAX_PREFIX  = VALUE_WIDTH - K
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic                   bin_valid_i,
   input  logic                   bin_i,
   output logic                   bin_ready_o,
   output logic [VALUE_WIDTH-1:0] value_o,
   output logic [7:0]             bin_length_o,
   output logic                   done_o,
   output logic                   err_o
);

   localparam int ACC_W = VALUE_WIDTH + 1;
   localparam int KMAX  = K + MAX_PREFIX;
   localparam int KW    = (KMAX < 1) ? 1 : $clog2(KMAX + 1);
   localparam int PW    = (MAX_PREFIX < 1) ? 1 : $clog2(MAX_PREFIX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREFIX,
      S_SUFFIX,
      S_DONE
   } state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [KW-1:0]    k;
   logic [KW-1:0]    scnt;
   logic [PW-1:0]    pcnt;
   logic [ACC_W-1:0] suf;
   logic [7:0]       len;

   logic             accept;
   logic             last_bin;
   logic             prefix_full;
   logic [ACC_W:0]   pre_sum;
   logic             pre_ovf;
   logic [ACC_W-1:0] suf_sh;
   logic [ACC_W:0]   fin_sum;
   logic             fin_ovf;
   logic [ACC_W-1:0] map_acc;
   logic             map_ovf;
   logic [VALUE_WIDTH-1:0] map_value;
   logic             range_err;
   logic             res_err;
   logic [VALUE_WIDTH-1:0] res_value;

   assign bin_ready_o = (state == S_PREFIX) || (state == S_SUFFIX);
   assign accept      = bin_valid_i && bin_ready_o;
   assign prefix_full = (pcnt == PW'(MAX_PREFIX));

   // Overflow is tracked sticky so a codeNum wider than acc is never silently truncated.
   always_comb begin
      pre_sum = {1'b0, acc} + ({{ACC_W{1'b0}}, 1'b1} << k);
      pre_ovf = pre_sum[ACC_W] || (32'(k) > ACC_W);
      suf_sh  = {suf[ACC_W-2:0], bin_i};
      fin_sum = {1'b0, acc} + {1'b0, suf_sh};
      fin_ovf = ovf || fin_sum[ACC_W] || suf[ACC_W-1];
   end

   always_comb begin
      last_bin = 1'b0;
      if (accept) begin
         if (state == S_PREFIX)
            last_bin = bin_i ? prefix_full : (k == '0);
         else
            last_bin = (scnt == KW'(1));
      end
   end

   always_comb begin
      if (state == S_SUFFIX) begin
         map_acc = fin_sum[ACC_W-1:0];
         map_ovf = fin_ovf;
      end else begin
         map_acc = acc;
         map_ovf = ovf;
      end
   end

`ifdef EGK_SIGNED_MAP_EN
   localparam logic [ACC_W-1:0] NEG_LIM = ACC_W'(1) << (VALUE_WIDTH - 1);
   localparam logic [ACC_W-1:0] POS_LIM = NEG_LIM - ACC_W'(1);

   logic [ACC_W:0]   odd_sum;
   logic [ACC_W-1:0] mag;

   // Odd codeNum is a positive value, even codeNum a zero or negative one.
   always_comb begin
      odd_sum = {1'b0, map_acc} + (ACC_W + 1)'(1);
      if (map_acc[0]) begin
         mag       = ACC_W'(odd_sum >> 1);
         range_err = (mag > POS_LIM);
         map_value = VALUE_WIDTH'(mag);
      end else begin
         mag       = {1'b0, map_acc[ACC_W-1:1]};
         range_err = (mag > NEG_LIM);
         map_value = VALUE_WIDTH'(ACC_W'(0) - mag);
      end
   end
`else
   always_comb begin
      range_err = map_acc[VALUE_WIDTH];
      map_value = map_acc[VALUE_WIDTH-1:0];
   end
`endif

   always_comb begin
      res_err   = map_ovf || range_err || ((state == S_PREFIX) && bin_i && prefix_full);
      res_value = res_err ? '0 : map_value;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         acc          <= '0;
         ovf          <= 1'b0;
         k            <= '0;
         scnt         <= '0;
         pcnt         <= '0;
         suf          <= '0;
         len          <= '0;
         value_o      <= '0;
         bin_length_o <= '0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  acc   <= '0;
                  ovf   <= 1'b0;
                  pcnt  <= '0;
                  len   <= '0;
                  k     <= KW'(K);
                  scnt  <= '0;
                  suf   <= '0;
                  state <= S_PREFIX;
               end
            end
            S_PREFIX: begin
               if (accept) begin
                  len <= len + 8'd1;
                  if (bin_i) begin
                     if (!prefix_full) begin
                        acc  <= pre_sum[ACC_W-1:0];
                        ovf  <= ovf || pre_ovf;
                        k    <= k + KW'(1);
                        pcnt <= pcnt + PW'(1);
                     end
                  end else begin
                     scnt  <= k;
                     suf   <= '0;
                     state <= S_SUFFIX;
                  end
               end
            end
            S_SUFFIX: begin
               if (accept) begin
                  len  <= len + 8'd1;
                  suf  <= suf_sh;
                  scnt <= scnt - KW'(1);
                  if (scnt == KW'(1)) begin
                     acc <= fin_sum[ACC_W-1:0];
                     ovf <= fin_ovf;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
         // Results are registered on the final bin so done_o follows it by one cycle.
         if (last_bin) begin
            value_o      <= res_value;
            err_o        <= res_err;
            bin_length_o <= len + 8'd1;
            done_o       <= 1'b1;
            state        <= S_DONE;
         end
      end
   end

endmodule

// File: tb/tb_egk_bin_decoder.sv
// tb/tb_egk_bin_decoder.sv - directed self-checking bench for egk_bin_decoder
module tb_egk_bin_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_i;
   logic       bin_valid_i;
   logic       bin_i;
   logic       bin_ready_o;
   logic [7:0] value_o;
   logic [7:0] bin_length_o;
   logic       done_o;
   logic       err_o;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int acc_cnt = 0;
   int d0;
   int a0;

   egk_bin_decoder #(.VALUE_WIDTH(8), .K(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .bin_valid_i  (bin_valid_i),
      .bin_i        (bin_i),
      .bin_ready_o  (bin_ready_o),
      .value_o      (value_o),
      .bin_length_o (bin_length_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done_o === 1'b1) done_cnt++;
   always @(posedge clk) if (bin_valid_i && bin_ready_o) acc_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_sym(input string tag, input logic [15:0] bits, input int n,
                          input int maxgap, input logic [7:0] exp_val, input logic exp_err);
      int dd;
      int aa;
      int g;
      dd = done_cnt;
      aa = acc_cnt;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
         g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         bin_valid_i = 1'b0;
         repeat (g) @(negedge clk);
         bin_valid_i = 1'b1;
         bin_i = bits[i];
         @(negedge clk);
      end
      bin_valid_i = 1'b0;
      check({tag, " done"}, done_o, 1);
      check({tag, " value"}, value_o, exp_val);
      check({tag, " length"}, bin_length_o, n);
      check({tag, " err"}, err_o, exp_err);
      check({tag, " ready_in_done"}, bin_ready_o, 0);
      @(negedge clk);
      check({tag, " done_pulse"}, done_o, 0);
      check({tag, " idle_ready"}, bin_ready_o, 0);
      check({tag, " done_count"}, done_cnt - dd, 1);
      check({tag, " accepted"}, acc_cnt - aa, n);
   endtask

   initial begin
      rst_n = 1'b0;
      start_i = 1'b0;
      bin_valid_i = 1'b0;
      bin_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst ready", bin_ready_o, 0);
      check("rst done", done_o, 0);
      check("rst err", err_o, 0);
      check("rst value", value_o, 0);
      check("rst length", bin_length_o, 0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef EGK_SIGNED_MAP_EN
      run_sym("t1_110011", 16'b110011, 6, 0, 8'd5, 1'b0);
      run_sym("t2_110000", 16'b110000, 6, 0, 8'hFD, 1'b0);
      run_sym("t2_00", 16'b00, 2, 0, 8'd0, 1'b0);
      run_sym("t2_1000", 16'b1000, 4, 0, 8'hFF, 1'b0);
      run_sym("t2_1001", 16'b1001, 4, 0, 8'd2, 1'b0);
      run_sym("t3_gaps", 16'b1011, 4, 3, 8'd3, 1'b0);
      run_sym("b_pos128", 16'hFE01, 16, 0, 8'd0, 1'b1);
      run_sym("b_neg128", 16'hFE02, 16, 0, 8'h80, 1'b0);
`else
      run_sym("t1_110011", 16'b110011, 6, 0, 8'd9, 1'b0);
      run_sym("t2_110000", 16'b110000, 6, 0, 8'd6, 1'b0);
      run_sym("t2_00", 16'b00, 2, 0, 8'd0, 1'b0);
      run_sym("t2_1000", 16'b1000, 4, 0, 8'd2, 1'b0);
      run_sym("t2_1001", 16'b1001, 4, 0, 8'd3, 1'b0);
      run_sym("t3_gaps", 16'b1011, 4, 3, 8'd5, 1'b0);
      run_sym("b_max255", 16'hFE01, 16, 0, 8'd255, 1'b0);
      run_sym("b_ovf256", 16'hFE02, 16, 0, 8'd0, 1'b1);
`endif
      run_sym("t4_prefix_ovf", 16'h00FF, 8, 0, 8'd0, 1'b1);

      // Abort in SUFFIX: 1,1,0 then one suffix bin, then reset.
      d0 = done_cnt;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      bin_valid_i = 1'b1;
      bin_i = 1'b1; @(negedge clk);
      bin_i = 1'b1; @(negedge clk);
      bin_i = 1'b0; @(negedge clk);
      bin_i = 1'b0; @(negedge clk);
      check("t5 mid_suffix_ready", bin_ready_o, 1);
      rst_n = 1'b0;
      #1;
      check("t5 async_ready", bin_ready_o, 0);
      bin_valid_i = 1'b0;
      @(negedge clk);
      check("t5 rst_err", err_o, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5 no_done", done_cnt - d0, 0);
      run_sym("t5_01", 16'b01, 2, 0, 8'd1, 1'b0);

      // start_i held 30 ns across a short symbol.
      d0 = done_cnt;
      a0 = acc_cnt;
      start_i = 1'b1;
      @(negedge clk);
      check("t6 prefix_ready", bin_ready_o, 1);
      bin_valid_i = 1'b1;
      bin_i = 1'b0; @(negedge clk);
      bin_i = 1'b1; @(negedge clk);
      start_i = 1'b0;
      bin_valid_i = 1'b0;
      check("t6 done", done_o, 1);
      check("t6 value", value_o, 1);
      check("t6 length", bin_length_o, 2);
      @(negedge clk);
      check("t6 idle1", bin_ready_o, 0);
      @(negedge clk);
      check("t6 idle2", bin_ready_o, 0);
      check("t6 one_symbol", done_cnt - d0, 1);
      check("t6 accepted", acc_cnt - a0, 2);

      // start_i held across DONE restarts in the first IDLE cycle.
      d0 = done_cnt;
      start_i = 1'b1;
      @(negedge clk);
      bin_valid_i = 1'b1;
      bin_i = 1'b0; @(negedge clk);
      bin_i = 1'b1; @(negedge clk);
      bin_valid_i = 1'b0;
      check("t6b done", done_o, 1);
      @(negedge clk);
      check("t6b idle", bin_ready_o, 0);
      @(negedge clk);
      check("t6b restart", bin_ready_o, 1);
      start_i = 1'b0;
      bin_valid_i = 1'b1;
      bin_i = 1'b0; @(negedge clk);
      bin_i = 1'b0; @(negedge clk);
      bin_valid_i = 1'b0;
      check("t6b done2", done_o, 1);
      check("t6b value2", value_o, 0);
      check("t6b length2", bin_length_o, 2);
      @(negedge clk);
      check("t6b count", done_cnt - d0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
